// File: rtl/vec_stream_out_if.sv
// Beat handshake bundle for vec_stream_out: payload, lane mask, valid/ready.
// Optional out_last is present only when VEC_STREAM_OUT_LAST_EN is defined.
interface vec_stream_out_if #(
    parameter int BITS  = 8,
    parameter int LANES = 1
);
    logic [LANES*BITS-1:0] out_data;
    logic [LANES-1:0]      out_keep;
    logic                  out_valid;
    logic                  out_ready;
`ifdef VEC_STREAM_OUT_LAST_EN
    logic                  out_last;

    modport master (output out_data, output out_keep, output out_valid, output out_last,
                     input out_ready);
    modport slave  (input out_data, input out_keep, input out_valid, input out_last,
                    output out_ready);
`else
    modport master (output out_data, output out_keep, output out_valid, input out_ready);
    modport slave  (input out_data, input out_keep, input out_valid, output out_ready);
`endif
endinterface

// File: rtl/vec_stream_out.sv
// vec_stream_out: captures a vector of up to N elements on set and streams it
// out LANES elements per beat over a valid/ready handshake.
// Optional feature: VEC_STREAM_OUT_LAST_EN adds out_last on the bus, high on
// the beat holding the final element.
//
// state  | meaning
// IDLE   | waiting for set; outputs quiet, out_count 0
// STREAM | presenting beats; advances on each accepted beat
// FINISH | single-cycle done pulse, then back to IDLE
module vec_stream_out #(
    parameter int BITS  = 8,
    parameter int N     = 64,
    parameter int LANES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BITS-1:0]     in [N],
    input  logic [$clog2(N):0]  in_len,
    input  logic                set,
    vec_stream_out_if.master    bus,
    output logic                busy,
    output logic                done,
    output logic [$clog2(N):0]  out_count
);
    localparam int CW = $clog2(N) + 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

    state_t                state;
    state_t                state_next;
    logic [BITS-1:0]       vec_reg [N];
    logic [CW-1:0]         len;
    logic [CW-1:0]         index;
    logic [CW-1:0]         len_clamp;
    logic [CW-1:0]         dec;
    logic [LANES*BITS-1:0] lane_data;
    logic [LANES-1:0]      lane_keep;
    logic                  xfer;

    assign len_clamp = (in_len > CW'(N)) ? CW'(N) : in_len;
    assign xfer      = (state == STREAM) && bus.out_ready;
    assign dec       = CW'($countones(lane_keep));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; the beat that empties out_count ends the stream.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (set) state_next = (len_clamp == '0) ? FINISH : STREAM;
            STREAM:  if (xfer && (out_count <= dec)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Vector and length capture; deliberately not reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && (state == IDLE) && set) begin
            vec_reg <= in;
            len     <= len_clamp;
        end
    end

    // Stream position and remaining-element count.
    always_ff @(posedge clk) begin
        if (rst) begin
            index     <= '0;
            out_count <= '0;
        end else if ((state == IDLE) && set) begin
            index     <= '0;
            out_count <= len_clamp;
        end else if (xfer) begin
            index     <= index + CW'(LANES);
            out_count <= (out_count > dec) ? (out_count - dec) : '0;
        end
    end

    // Lane selection: elements index..index+LANES-1, zeroed at or beyond len.
    always_comb begin
        lane_data = '0;
        lane_keep = '0;
        if (state == STREAM) begin
            for (int k = 0; k < LANES; k++) begin
                if (int'(index) + k < int'(len)) begin
                    lane_keep[k]              = 1'b1;
                    lane_data[k*BITS +: BITS] = vec_reg[IW'(int'(index) + k)];
                end
            end
        end
    end

    // Output decode from state.
    always_comb begin
        bus.out_valid = (state == STREAM);
        bus.out_data  = lane_data;
        bus.out_keep  = lane_keep;
        busy          = (state != IDLE);
        done          = (state == FINISH);
`ifdef VEC_STREAM_OUT_LAST_EN
        bus.out_last  = (state == STREAM) && (int'(index) + LANES >= int'(len));
`endif
    end
endmodule

// File: tb/tb_vec_stream_out.sv
// Bench for vec_stream_out: two instances (LANES=1/N=64 and LANES=4/N=8),
// a queue-based beat model per instance, and directed vectors.
module tb_vec_stream_out;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] in1 [64];
    logic [6:0] len1;
    logic       set1, busy1, done1;
    logic [6:0] cnt1;
    vec_stream_out_if #(.BITS(8), .LANES(1)) b1 ();

    logic [7:0] in4 [8];
    logic [3:0] len4;
    logic       set4, busy4, done4;
    logic [3:0] cnt4;
    vec_stream_out_if #(.BITS(8), .LANES(4)) b4 ();

    vec_stream_out #(.BITS(8), .N(64), .LANES(1)) u1 (
        .clk(clk), .rst(rst), .in(in1), .in_len(len1), .set(set1),
        .bus(b1), .busy(busy1), .done(done1), .out_count(cnt1));

    vec_stream_out #(.BITS(8), .N(8), .LANES(4)) u4 (
        .clk(clk), .rst(rst), .in(in4), .in_len(len4), .set(set4),
        .bus(b4), .busy(busy4), .done(done4), .out_count(cnt4));

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        int          count;
    } beat_t;

    beat_t q1[$];
    beat_t q4[$];
    bit    fin1, fin4;
    int    checks = 0;
    int    errors = 0;
    bit    chk_en = 0;
    int    nx1 = 0;
    int    nx4 = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Expected beat list from the captured vector: clamp, chunk by lanes, mask tail.
    task automatic build(input int id, input int lanes, input int n, input int len_in);
        int L;
        L = (len_in > n) ? n : len_in;
        for (int b = 0; b < L; b += lanes) begin
            beat_t bt;
            bt.data = '0;
            bt.keep = '0;
            for (int k = 0; k < lanes; k++) begin
                if (b + k < L) begin
                    bt.keep[k] = 1'b1;
                    if (id == 1) bt.data[k*8 +: 8] = in1[b+k];
                    else         bt.data[k*8 +: 8] = in4[b+k];
                end
            end
            bt.last  = (b + lanes >= L);
            bt.count = L - b;
            if (id == 1) q1.push_back(bt);
            else         q4.push_back(bt);
        end
        if (L == 0) begin
            if (id == 1) fin1 = 1;
            else         fin4 = 1;
        end
    endtask

    // Model advance on each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            q1.delete(); fin1 = 0;
        end else if (fin1) fin1 = 0;
        else if (q1.size() > 0) begin
            if (b1.out_ready) begin
                q1.delete(0);
                if (q1.size() == 0) fin1 = 1;
            end
        end else if (set1) build(1, 1, 64, int'(len1));

        if (rst) begin
            q4.delete(); fin4 = 0;
        end else if (fin4) fin4 = 0;
        else if (q4.size() > 0) begin
            if (b4.out_ready) begin
                q4.delete(0);
                if (q4.size() == 0) fin4 = 1;
            end
        end else if (set4) build(4, 4, 8, int'(len4));
    end

    // Accepted-beat counters taken from the DUT handshake itself.
    always @(posedge clk) begin
        if (!rst && b1.out_valid && b1.out_ready) nx1++;
        if (!rst && b4.out_valid && b4.out_ready) nx4++;
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("u1_valid", b1.out_valid, q1.size() > 0);
            cmp("u1_data",  b1.out_data,  q1.size() > 0 ? q1[0].data : 0);
            cmp("u1_keep",  b1.out_keep,  q1.size() > 0 ? q1[0].keep : 0);
            cmp("u1_count", cnt1,         q1.size() > 0 ? q1[0].count : 0);
            cmp("u1_busy",  busy1,        (q1.size() > 0) || fin1);
            cmp("u1_done",  done1,        fin1);
            cmp("u4_valid", b4.out_valid, q4.size() > 0);
            cmp("u4_data",  b4.out_data,  q4.size() > 0 ? q4[0].data : 0);
            cmp("u4_keep",  b4.out_keep,  q4.size() > 0 ? q4[0].keep : 0);
            cmp("u4_count", cnt4,         q4.size() > 0 ? q4[0].count : 0);
            cmp("u4_busy",  busy4,        (q4.size() > 0) || fin4);
            cmp("u4_done",  done4,        fin4);
`ifdef VEC_STREAM_OUT_LAST_EN
            cmp("u1_last",  b1.out_last,  q1.size() > 0 ? q1[0].last : 0);
            cmp("u4_last",  b4.out_last,  q4.size() > 0 ? q4[0].last : 0);
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_done1(input int max, input bit toggle);
        int c = 0;
        bit seen = 0;
        while (!seen && c < max) begin
            if (toggle) b1.out_ready = (c % 3 != 2);
            tick();
            c++;
            if (done1) seen = 1;
        end
        b1.out_ready = 1'b1;
        cmp("u1_done_reached", seen, 1);
    endtask

    task automatic wait_done4(input int max);
        int c = 0;
        bit seen = 0;
        while (!seen && c < max) begin
            tick();
            c++;
            if (done4) seen = 1;
        end
        cmp("u4_done_reached", seen, 1);
    endtask

    initial begin
        int base1, base4;
        rst = 1'b1;
        set1 = 0; set4 = 0; len1 = '0; len4 = '0;
        b1.out_ready = 1'b1;
        b4.out_ready = 1'b1;
        for (int i = 0; i < 64; i++) in1[i] = 8'(i + 1);
        for (int i = 0; i < 8; i++)  in4[i] = 8'(8'h10 + i);
        tick(); tick();
        chk_en = 1;
        cmp("rst_busy1", busy1, 0);
        cmp("rst_cnt1", cnt1, 0);
        cmp("rst_valid4", b4.out_valid, 0);
        rst = 1'b0;
        tick();

        // L=4, one lane, ready high
        len1 = 7'd4; set1 = 1; tick(); set1 = 0;
        cmp("t1_d0", b1.out_data, 8'd1); cmp("t1_c0", cnt1, 7'd4);
        tick(); cmp("t1_d1", b1.out_data, 8'd2); cmp("t1_c1", cnt1, 7'd3);
        tick(); cmp("t1_d2", b1.out_data, 8'd3); cmp("t1_c2", cnt1, 7'd2);
        tick(); cmp("t1_d3", b1.out_data, 8'd4); cmp("t1_c3", cnt1, 7'd1);
        tick(); cmp("t1_done", done1, 1); cmp("t1_vlow", b1.out_valid, 0);
        tick(); cmp("t1_idle", busy1, 0);

        // L=6, four lanes: partial second beat
        len4 = 4'd6; set4 = 1; tick(); set4 = 0;
        cmp("t2_k0", b4.out_keep, 4'b1111); cmp("t2_d0", b4.out_data, 32'h13121110);
        cmp("t2_c0", cnt4, 4'd6);
        tick();
        cmp("t2_k1", b4.out_keep, 4'b0011); cmp("t2_d1", b4.out_data, 32'h00001514);
        cmp("t2_c1", cnt4, 4'd2);
`ifdef VEC_STREAM_OUT_LAST_EN
        cmp("t2_last", b4.out_last, 1);
`endif
        tick(); cmp("t2_done", done4, 1);
        tick();

        // L=0: straight to the done pulse
        len4 = 4'd0; set4 = 1; tick(); set4 = 0;
        cmp("t3_busy", busy4, 1); cmp("t3_done", done4, 1); cmp("t3_valid", b4.out_valid, 0);
        tick(); cmp("t3_idle", busy4, 0);

        // back-pressure for three cycles mid-stream
        len1 = 7'd5; set1 = 1; tick(); set1 = 0;
        tick();
        b1.out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("t4_hold_d", b1.out_data, 8'd2);
            cmp("t4_hold_c", cnt1, 7'd4);
        end
        b1.out_ready = 1;
        tick(); cmp("t4_resume", b1.out_data, 8'd3); cmp("t4_rc", cnt1, 7'd3);
        wait_done1(20, 0);
        tick();

        // set during STREAM is ignored
        len1 = 7'd6; set1 = 1; tick(); set1 = 0;
        tick();
        for (int i = 0; i < 64; i++) in1[i] = 8'(8'hA0 + i);
        len1 = 7'd2; set1 = 1; tick(); set1 = 0;
        cmp("t5_orig", b1.out_data, 8'd3);
        wait_done1(20, 0);
        tick();

        // reset mid-stream on both instances
        len1 = 7'd10; set1 = 1; len4 = 4'd8; set4 = 1; tick(); set1 = 0; set4 = 0;
        tick();
        rst = 1; tick();
        cmp("t6_v1", b1.out_valid, 0); cmp("t6_c1", cnt1, 0); cmp("t6_b1", busy1, 0);
        cmp("t6_d1", b1.out_data, 0); cmp("t6_v4", b4.out_valid, 0); cmp("t6_k4", b4.out_keep, 0);
        rst = 0; tick();

        // oversize length clamps to N; uneven ready on the one-lane instance
        for (int i = 0; i < 64; i++) in1[i] = 8'(i * 7 + 3);
        base1 = nx1; base4 = nx4;
        len1 = 7'd65; set1 = 1; len4 = 4'd9; set4 = 1; tick(); set1 = 0; set4 = 0;
        cmp("t7_c1", cnt1, 7'd64); cmp("t7_c4", cnt4, 4'd8);
        wait_done4(10);
        wait_done1(200, 1);
        cmp("t7_n1", nx1 - base1, 64);
        cmp("t7_n4", nx4 - base4, 2);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vec_stream_out.md
VEC_STREAM_OUT -- requirements
Module: vec_stream_out

Interface
REQ-001 Parameter BITS, default 8, element width in bits.
REQ-002 Parameter N, default 64, vector depth in elements.
REQ-003 Parameter LANES, default 1, elements per output beat; N SHALL be a multiple of LANES.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 in  input  BITS x N unpacked array  source vector, element 0 first.
REQ-007 in_len  input  $clog2(N)+1  number of elements to emit.
REQ-008 set  input  1  load request, sampled each rising edge.
REQ-009 out_data  output  LANES*BITS  beat payload; lane k occupies bits [k*BITS +: BITS].
REQ-010 out_keep  output  LANES  per-lane valid mask.
REQ-011 out_valid  output  1  beat available.
REQ-012 out_ready  input  1  sink accepts beat.
REQ-013 busy  output  1  high while state is not IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 out_count  output  $clog2(N)+1  elements not yet accepted.

Function
REQ-016 States SHALL be IDLE, STREAM and FINISH.
REQ-017 In IDLE, set high at a rising edge SHALL capture in[] into an internal register and capture in_len, clamped to N, as the length L.
REQ-018 The same edge SHALL set index to 0 and out_count to L; the block SHALL enter STREAM if L>0, else FINISH.
REQ-019 set asserted outside IDLE SHALL be ignored; the captured data and L SHALL stay unchanged.
REQ-020 In STREAM, out_valid SHALL be high, and out_data and out_keep SHALL hold elements index..index+LANES-1.
REQ-021 Lanes at or beyond L SHALL have keep=0 and data=0.
REQ-022 A beat transfers on a rising edge with out_valid and out_ready both high.
REQ-023 While out_valid is high and out_ready is low, out_data and out_keep SHALL hold stable.
REQ-024 On each transfer, index SHALL advance by LANES and out_count SHALL drop by popcount(out_keep), never below 0.
REQ-025 The transfer that brings out_count to 0 SHALL move the state to FINISH; out_valid SHALL be low in the following cycle.
REQ-026 FINISH SHALL last exactly one cycle with done=1, busy=1, out_valid=0, then return to IDLE.
REQ-027 Latency: first beat SHALL be valid the cycle after set is captured; with out_ready held high, the throughput SHALL be one beat per cycle.
REQ-028 In IDLE, out_valid=0, out_keep=0, out_data=0 and busy=0; out_count SHALL hold 0.

Reset
REQ-029 rst high at a rising edge SHALL force IDLE, out_valid=0, out_keep=0, out_data=0, out_count=0, done=0 and busy=0, overriding set and any in-flight stream.
REQ-030 Reset SHALL NOT clear the captured vector register contents.

Configuration
REQ-031 With VEC_STREAM_OUT_LAST_EN defined, output out_last (1 bit) SHALL exist and be high exactly when out_valid is high and the current beat holds element L-1.
REQ-032 Without VEC_STREAM_OUT_LAST_EN, port out_last SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 LANES=1, L=4, in[i]=i+1, out_ready=1 -> beats 1,2,3,4 on consecutive cycles, out_count 4,3,2,1; done pulses one cycle after beat 4.
REQ-034 LANES=4, L=6 -> beat 0 has keep=4'b1111; beat 1 has keep=4'b0011, lanes 2-3 data 0, out_last=1 when the macro is defined.
REQ-035 L=0 -> no out_valid; done pulses the cycle after set; busy high for 1 cycle.
REQ-036 out_ready low for 3 cycles mid-stream -> out_data stable, out_count unchanged; resumes at the same element.
REQ-037 set pulsed during STREAM with a new vector -> ignored, original data completes; rst mid-stream -> all outputs 0 next cycle, IDLE.
REQ-038 in_len=N+1 encoding (e.g. 65 with N=64) -> clamped, exactly 64 elements emitted.
